softmax_argmax: RTL

- Downstream consumer of the 7-class softmax stage. Captures the probability vector on valid_in and serially scans it for the maximum. Reports the winning class index and its probability with a one-cycle valid_out pulse.
- Sits between the softmax output and the classification result register or host readout.
- Multi-cycle, non-pipelined: in_ready drops while a scan is in progress.

---
 rtl/softmax_pkg.sv | 19 +
 rtl/fp32_gt.sv | 29 ++
 rtl/softmax_argmax.sv | 123 ++++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared constants, FSM encoding and fp32 NaN helper for softmax_argmax
package softmax_pkg;

    localparam int NUM_CLASSES = 7;
    localparam int FP_W        = 32;
    localparam int IDX_W       = 3;
    localparam logic [7:0] FP_EXP_ALL1 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic fp32_is_nan(input logic [FP_W-1:0] x);
        return (x[30:23] == FP_EXP_ALL1) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp32_gt.sv
// rtl/fp32_gt.sv - combinational signed IEEE-754 single-precision strict greater-than
module fp32_gt
    import softmax_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            a_gt_b
);

    logic both_zero;
    logic ordered_gt;

    always_comb begin
        both_zero  = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
        ordered_gt = 1'b0;
        if (both_zero) begin
            ordered_gt = 1'b0;
        end else if (a[31] != b[31]) begin
            ordered_gt = !a[31];
        end else if (!a[31]) begin
            ordered_gt = a[30:0] > b[30:0];
        end else begin
            ordered_gt = a[30:0] < b[30:0];
        end
        // A NaN never wins, and any real number beats a NaN incumbent.
        a_gt_b = !fp32_is_nan(a) && (fp32_is_nan(b) || ordered_gt);
    end

endmodule

// File: rtl/softmax_argmax.sv
// rtl/softmax_argmax.sv - serial argmax over captured softmax vector; optional SOFTMAX_ARGMAX_THRESH_EN adds thresh/low_conf
module softmax_argmax
    import softmax_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [FP_W-1:0]  class0,
    input  logic [FP_W-1:0]  class1,
    input  logic [FP_W-1:0]  class2,
    input  logic [FP_W-1:0]  class3,
    input  logic [FP_W-1:0]  class4,
    input  logic [FP_W-1:0]  class5,
    input  logic [FP_W-1:0]  class6,
    output logic             in_ready,
    output logic             valid_out,
    output logic [IDX_W-1:0] class_idx,
    output logic [FP_W-1:0]  class_prob,
`ifdef SOFTMAX_ARGMAX_THRESH_EN
    input  logic [FP_W-1:0]  thresh,
    output logic             low_conf,
`endif
    output logic             overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [FP_W-1:0]  cap_buf [NUM_CLASSES];
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] best_idx;
    logic [FP_W-1:0]  best_val;
    logic             cand_gt;

    fp32_gt u_scan_cmp (
        .a      (cap_buf[cnt]),
        .b      (best_val),
        .a_gt_b (cand_gt)
    );

`ifdef SOFTMAX_ARGMAX_THRESH_EN
    logic [FP_W-1:0] thresh_q;
    logic            thresh_gt_best;

    fp32_gt u_thresh_cmp (
        .a      (thresh_q),
        .b      (best_val),
        .a_gt_b (thresh_gt_best)
    );
`endif

    assign in_ready = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in) state_d = SCAN;
            SCAN:    if (cnt == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) cap_buf[i] <= '0;
            cnt        <= '0;
            best_idx   <= '0;
            best_val   <= '0;
            valid_out  <= 1'b0;
            class_idx  <= '0;
            class_prob <= '0;
            overrun    <= 1'b0;
`ifdef SOFTMAX_ARGMAX_THRESH_EN
            thresh_q   <= '0;
            low_conf   <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            if (valid_in && state_q != IDLE) overrun <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        cap_buf  <= '{class0, class1, class2, class3, class4, class5, class6};
                        best_idx <= '0;
                        best_val <= class0;
                        cnt      <= IDX_W'(1);
`ifdef SOFTMAX_ARGMAX_THRESH_EN
                        thresh_q <= thresh;
`endif
                    end
                end
                SCAN: begin
                    if (cand_gt) begin
                        best_idx <= cnt;
                        best_val <= cap_buf[cnt];
                    end
                    // Hold at the last index so the compare never reads past the buffer.
                    if (cnt != LAST_IDX) cnt <= cnt + IDX_W'(1);
                end
                DONE: begin
                    class_idx  <= best_idx;
                    class_prob <= best_val;
                    valid_out  <= 1'b1;
`ifdef SOFTMAX_ARGMAX_THRESH_EN
                    low_conf   <= fp32_is_nan(best_val) || thresh_gt_best;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
